// File: rtl/elastic_shift_fifo.sv
// elastic_shift_fifo: multi-entry valid/ready elastic buffer. Every accepted
// word is shifted left by SHIFT (truncated to DW bits) on its way into storage.
// The head entry is presented registered; there is no flow-through path.
// Optional build macro ELASTIC_SHIFT_OVF_EN enables the sticky ovf flag, which
// records any push that loses nonzero bits off the top of the shift. When the
// macro is undefined, ovf is tied low.
module elastic_shift_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  parameter  int SHIFT = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic [DW-1:0] t_data,
  input  logic          t_valid,
  output logic          t_ready,
  output logic [DW-1:0] i_data,
  output logic          i_valid,
  input  logic          i_ready,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Left shift with the upper SHIFT bits dropped and zeros filled in at the bottom.
  function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] d);
    return d << SHIFT;
  endfunction

  // Flow control. When full, a pop in this cycle frees the slot for this
  // cycle's push, so t_ready follows i_ready combinationally. rstf gates
  // t_ready so that no handshake completes while reset is held.
  always_comb begin
    t_ready = rstf & ((count != FULL_CNT) | i_ready);
    i_valid = (count != '0);
    i_data  = mem[rd_ptr];
    push    = t_valid & t_ready;
    pop     = i_valid & i_ready;
  end

  // Storage write: the shifted word lands at the tail.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= shift_word(t_data);
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ELASTIC_SHIFT_OVF_EN
  logic ovf_q;

  // Detect nonzero bits in the top SHIFT positions, which the shift discards.
  // The mask form covers SHIFT == 0 (empty mask) without a zero-width slice.
  function automatic logic lost_bits(input logic [DW-1:0] d);
    logic [DW-1:0] keep;
    keep = {DW{1'b1}} >> SHIFT;
    return |(d & ~keep);
  endfunction

  // Sticky overflow: it sets on an accepted lossy word and clears only on reset.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf)                         ovf_q <= 1'b0;
    else if (push && lost_bits(t_data)) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_shift_fifo.sv
// Bench for elastic_shift_fifo: a vector table, hand-written corner sequences,
// and a queue scoreboard that checks every popped word against the order in
// which words were accepted.
module tb_elastic_shift_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SHIFT = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstf;
  logic [DW-1:0] t_data;
  logic          t_valid;
  logic          t_ready;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_ready;
  logic [CW-1:0] count;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  elastic_shift_fifo #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rstf(rstf),
    .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] td;
    logic          tv;
    logic          ir;
    logic          ev;
    logic          cd;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          er;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Samples the handshakes at the falling edge, advances one rising edge,
  // then compares occupancy against the scoreboard depth.
  task automatic tick();
    @(negedge clk);
    if (t_valid && t_ready) sb.push_back(t_data << SHIFT);
    if (i_valid && i_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_pop", 32'd1, 32'd0);
      else                chk("sb_data", i_data, sb.pop_front());
    end
    @(posedge clk);
    #1;
    chk("count_vs_model", 32'(count), 32'(sb.size()));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Columns: td, tv, ir, ev, cd, ed, ec, er
    vecs[0]  = '{32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  3'd1, 1'b1};
    vecs[1]  = '{32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  3'd2, 1'b1};
    vecs[2]  = '{32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  3'd3, 1'b1};
    vecs[3]  = '{32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  3'd4, 1'b0};
    vecs[4]  = '{32'h5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  3'd4, 1'b0};
    vecs[5]  = '{32'h5,  1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  3'd4, 1'b1};
    vecs[6]  = '{32'h5,  1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  3'd3, 1'b1};
    vecs[7]  = '{32'h5,  1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 3'd2, 1'b1};
    vecs[8]  = '{32'h5,  1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 3'd1, 1'b1};
    vecs[9]  = '{32'h5,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1};
    vecs[10] = '{32'hA,  1'b1, 1'b0, 1'b1, 1'b1, 32'h28, 3'd1, 1'b1};
    vecs[11] = '{32'hB,  1'b1, 1'b0, 1'b1, 1'b1, 32'h28, 3'd2, 1'b1};
    vecs[12] = '{32'hC,  1'b1, 1'b1, 1'b1, 1'b1, 32'h2C, 3'd2, 1'b1};
    vecs[13] = '{32'hC,  1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 3'd1, 1'b1};
    vecs[14] = '{32'hC,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1};

    rstf    = 1'b0;
    t_data  = '0;
    t_valid = 1'b0;
    i_ready = 1'b1;
    #12;
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_i_valid", 32'(i_valid), 32'd0);
    chk("rst_t_ready", 32'(t_ready), 32'd0);
    chk("rst_i_data",  i_data,       32'h0);
    chk("rst_ovf",     32'(ovf),     32'd0);
    @(posedge clk);
    #1;
    rstf    = 1'b1;
    i_ready = 1'b0;

    // Single word, fill to full with a held 5th word, drain, then push and pop together at count 2
    for (int k = 0; k < 15; k++) begin
      t_data  = vecs[k].td;
      t_valid = vecs[k].tv;
      i_ready = vecs[k].ir;
      tick();
      chk($sformatf("vec%0d_i_valid", k), 32'(i_valid), 32'(vecs[k].ev));
      if (vecs[k].cd) chk($sformatf("vec%0d_i_data", k), i_data, vecs[k].ed);
      chk($sformatf("vec%0d_count", k),   32'(count),   32'(vecs[k].ec));
      chk($sformatf("vec%0d_t_ready", k), 32'(t_ready), 32'(vecs[k].er));
      chk($sformatf("vec%0d_ovf", k),     32'(ovf),     32'd0);
    end

    // Streaming at full rate across two pointer wraps
    for (int k = 0; k < 10; k++) begin
      t_data  = 32'(k);
      t_valid = 1'b1;
      i_ready = 1'b1;
      tick();
      chk($sformatf("stream%0d_i_valid", k), 32'(i_valid), 32'd1);
      chk($sformatf("stream%0d_i_data", k),  i_data,       32'(k * 4));
      chk($sformatf("stream%0d_count", k),   32'(count),   32'd1);
    end
    t_valid = 1'b0;
    tick();
    chk("stream_drain_count", 32'(count), 32'd0);

    // Reset mid-operation with three entries stored
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      t_data  = 32'h11 + 32'(k);
      t_valid = 1'b1;
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    t_data  = 32'h99;
    t_valid = 1'b1;
    i_ready = 1'b1;
    rstf    = 1'b0;
    #1;
    chk("midrst_t_ready", 32'(t_ready), 32'd0);
    chk("midrst_i_valid", 32'(i_valid), 32'd0);
    chk("midrst_count",   32'(count),   32'd0);
    chk("midrst_i_data",  i_data,       32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold_count", 32'(count), 32'd0);
    rstf    = 1'b1;
    t_data  = 32'h5;
    t_valid = 1'b1;
    i_ready = 1'b0;
    tick();
    chk("postrst_i_valid", 32'(i_valid), 32'd1);
    chk("postrst_i_data",  i_data,       32'h14);
    t_valid = 1'b0;
    i_ready = 1'b1;
    tick();

    // Shift overflow flag
    t_data  = 32'h8000_0000;
    t_valid = 1'b1;
    i_ready = 1'b0;
    tick();
    chk("ovf_word_data", i_data, 32'h0);
`ifdef ELASTIC_SHIFT_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`else
    chk("ovf_tied_low", 32'(ovf), 32'd0);
`endif
    t_data = 32'h1;
    tick();
`ifdef ELASTIC_SHIFT_OVF_EN
    chk("ovf_sticky", 32'(ovf), 32'd1);
`else
    chk("ovf_tied_low2", 32'(ovf), 32'd0);
`endif
    t_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    chk("ovf_drain_count", 32'(count), 32'd0);

    // The flag clears only through reset
    rstf = 1'b0;
    #1;
    chk("final_rst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rstf = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_shift_fifo.md
Name: elastic_shift_fifo

Overview:
- Parametrised multi-entry elastic buffer with valid/ready handshake on both sides; replaces single-register elastic stages on datapath channels.
- Applies a fixed left shift by SHIFT to each accepted word at write time.
- Sits between a producer (t_ side) and a consumer (i_ side) in the clk domain.
- Exposes occupancy to flow-control logic.

Parameters:
- DW, 32: data width in bits, ≥1; input and output widths are equal.
- DEPTH, 4: number of entries; power of 2, ≥2.
- SHIFT, 2: left-shift amount applied to written data, 0 ≤ SHIFT < DW.
- CW, $clog2(DEPTH+1): count width; derived, not overridden.

Ports:
- clk  in  1  clock; all state on posedge.
- rstf  in  1  asynchronous active-low reset.
- t_data  in  DW  upstream data.
- t_valid  in  1  upstream valid.
- t_ready  out  1  upstream ready.
- i_data  out  DW  downstream data (head entry).
- i_valid  out  1  downstream valid.
- i_ready  in  1  downstream ready.
- count  out  CW  current number of stored entries, 0..DEPTH.
- ovf  out  1  sticky shift-overflow flag; see Optional Feature.

Behaviour:
- Reset (rstf low, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - All storage entries are 0.
  - i_valid = 0, i_data = 0, ovf = 0.
  - t_ready = 0 while rstf is low, gated combinationally.
  - Reset mid-transfer discards all stored entries; no handshake completes in that cycle.
- push = t_valid & t_ready; pop = i_valid & i_ready.
- t_ready = rstf & ((count != DEPTH) | i_ready).
  - When full, a push is accepted in the same cycle as a pop.
  - This path is combinational from i_ready, matching the single-stage behaviour.
- i_valid = (count != 0); i_data = mem[rd_ptr]. Both are combinational from registered state.
- On push: mem[wr_ptr] <= (t_data << SHIFT) truncated to DW bits, i.e. upper SHIFT bits are dropped and lower SHIFT bits are 0. wr_ptr increments modulo DEPTH.
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on push and pop together, or on neither.
- Latency: a word accepted at edge N is visible on i_data/i_valid after edge N. There is no combinational t_data-to-i_data path, even when empty.
- Throughput: one word per cycle sustained in any state while i_ready = 1.
- Empty: i_valid = 0. i_data shows a stale or zero entry and must not be sampled.
- Full: t_ready follows i_ready.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0; ordering is preserved across the wrap.
- Data held at i_data is stable while i_valid = 1 and i_ready = 0.
- t_valid/t_data may change freely when t_ready = 0; nothing is captured.

Optional Feature:
- Macro: ELASTIC_SHIFT_OVF_EN
- Defined:
  - On a push where t_data[DW-1 -: SHIFT] != 0, ovf sets to 1 at that edge.
  - ovf stays 1 until rstf is asserted.
  - With SHIFT = 0, ovf stays 0.
- Not defined: ovf is tied to 0 and no detection logic is built. The port is always present.

Test Plan:
- Reset then single word: DW=32, SHIFT=2. Push 0x0000_0001 with i_ready=0. Next cycle: i_valid=1, i_data=0x0000_0004, count=1, t_ready=1.
- Fill to full: DEPTH=4, i_ready=0. Push 0x1, 0x2, 0x3, 0x4 → count=4, t_ready=0. A 5th word held on t_valid is not captured. Raise i_ready → pops 0x4, 0x8, 0xC, 0x10 in order; the 5th word is accepted in the first pop cycle.
- Streaming with wrap: t_valid=1 and i_ready=1 for 10 cycles with data 0..9 → output 0x0, 0x4, …, 0x24, one per cycle; count stays 1 after the first edge; pointers wrap twice with no loss.
- Simultaneous push/pop at count=2 → count stays 2; head advances; new word lands at the tail.
- Reset mid-operation: count=3, assert rstf low for 1 cycle → i_valid=0, count=0, t_ready=0 during reset. After release, first push of 0x5 emerges as 0x14.
- ELASTIC_SHIFT_OVF_EN: push 0x8000_0000 → ovf=1 after that edge and the stored word is 0x0000_0000. Push 0x1 → ovf stays 1. Without the macro, ovf is 0 throughout.
